// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use hazard detection with a saturating stall-cycle counter
module hazard_detection_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] rm_ID,
  input  logic [REG_BITS-1:0] rn_ID,
  input  logic [REG_BITS-1:0] rd_EX,
  input  logic [REG_BITS-1:0] rd_MEM,
  input  logic                regwrite_EX,
  input  logic                regwrite_MEM,
  input  logic                memread_EX,
  output logic                pc_stall,
  output logic                id_bubble,
  output logic                ifid_write,
  output logic [CNT_BITS-1:0] stall_count
);
  logic                w_hazard;
  logic                w_unused;
  logic [CNT_BITS-1:0] r_count;
  assign w_hazard    = memread_EX && (rd_EX != '0) && ((rd_EX == rm_ID) || (rd_EX == rn_ID));
  assign w_unused    = ^{rd_MEM, regwrite_MEM, regwrite_EX};
  assign pc_stall    = w_hazard;
  assign id_bubble   = w_hazard;
  assign ifid_write  = ~w_hazard;
  assign stall_count = r_count;
  // count stall cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else if (w_hazard && !(&r_count)) r_count <= r_count + {{(CNT_BITS-1){1'b0}}, 1'b1};
  end
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed scoreboard bench for hazard_detection_unit
module tb_hazard_detection_unit;
  typedef struct {
    string       tag;
    logic [2:0]  comb;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
    logic        chk_cnt;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rm_ID = '0, rn_ID = '0, rd_EX = '0, rd_MEM = '0;
  logic        regwrite_EX = 1'b0, regwrite_MEM = 1'b0, memread_EX = 1'b0;
  logic        pc_stall, id_bubble, ifid_write, pc_stall4, id_bubble4, ifid_write4;
  logic [15:0] stall_count;
  logic [3:0]  stall_count4;
  logic [15:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;
  logic        m_valid = 1'b0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  hazard_detection_unit dut (
    .clk(clk), .rst(rst), .rm_ID(rm_ID), .rn_ID(rn_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM),
    .regwrite_EX(regwrite_EX), .regwrite_MEM(regwrite_MEM), .memread_EX(memread_EX),
    .pc_stall(pc_stall), .id_bubble(id_bubble), .ifid_write(ifid_write), .stall_count(stall_count)
  );
  hazard_detection_unit #(.REG_BITS(5), .CNT_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .rm_ID(rm_ID), .rn_ID(rn_ID), .rd_EX(rd_EX), .rd_MEM(rd_MEM),
    .regwrite_EX(regwrite_EX), .regwrite_MEM(regwrite_MEM), .memread_EX(memread_EX),
    .pc_stall(pc_stall4), .id_bubble(id_bubble4), .ifid_write(ifid_write4), .stall_count(stall_count4)
  );
  always #5 clk = ~clk;
  function automatic logic model_hazard();
    return memread_EX && (rd_EX != 5'd0) && ((rd_EX == rm_ID) || (rd_EX == rn_ID));
  endfunction
  task automatic push(input string tag);
    exp_t e;
    logic h;
    h = model_hazard();
    e.tag = tag;
    e.comb = {h, h, ~h};
    e.cnt = m_cnt;
    e.cnt4 = m_cnt4;
    e.chk_cnt = m_valid;
    sb.push_back(e);
  endtask
  task automatic check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert ({pc_stall, id_bubble, ifid_write} === e.comb) else begin
      errors++;
      $error("FAIL %s outputs: got %b expected %b", e.tag, {pc_stall, id_bubble, ifid_write}, e.comb);
    end
    checks++;
    assert ({pc_stall4, id_bubble4, ifid_write4} === e.comb) else begin
      errors++;
      $error("FAIL %s outputs4: got %b expected %b", e.tag, {pc_stall4, id_bubble4, ifid_write4}, e.comb);
    end
    if (e.chk_cnt) begin
      checks++;
      assert (stall_count === e.cnt) else begin
        errors++;
        $error("FAIL %s count: got %0d expected %0d", e.tag, stall_count, e.cnt);
      end
      checks++;
      assert (stall_count4 === e.cnt4) else begin
        errors++;
        $error("FAIL %s count4: got %0d expected %0d", e.tag, stall_count4, e.cnt4);
      end
    end
  endtask
  task automatic drive(input string tag, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rde,
                       input logic [4:0] rdm, input logic rwe, input logic rwm, input logic mre);
    rm_ID = rm; rn_ID = rn; rd_EX = rde; rd_MEM = rdm;
    regwrite_EX = rwe; regwrite_MEM = rwm; memread_EX = mre;
    #1;
    push(tag);
    check();
  endtask
  task automatic step(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) begin
        m_cnt = '0;
        m_cnt4 = '0;
        m_valid = 1'b1;
      end else if (model_hazard()) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
      #1;
      push(tag);
      check();
    end
  endtask
  initial begin
    rst = 1'b1;
    drive("idle_rst", 5'd1, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
    step("reset", 1);
    rst = 1'b0;
    step("idle_hold", 2);
    drive("load_rm_noregwrite", 5'd1, 5'd2, 5'd1, 5'd4, 1'b0, 1'b0, 1'b1);
    drive("zero_reg", 5'd0, 5'd2, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1);
    drive("load_rn", 5'd1, 5'd2, 5'd2, 5'd4, 1'b0, 1'b0, 1'b1);
    drive("both_match", 5'd7, 5'd7, 5'd7, 5'd4, 1'b1, 1'b0, 1'b1);
    drive("nonload_ex", 5'd1, 5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    drive("mem_match", 5'd1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b0);
    drive("load_nomatch_mem", 5'd1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1);
    step("no_count", 2);
    rst = 1'b1;
    step("pulse_rst", 1);
    rst = 1'b0;
    drive("hazard_on", 5'd9, 5'd2, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1);
    step("count5", 5);
    rst = 1'b1;
    step("rst_in_hazard", 1);
    drive("stall_during_rst", 5'd9, 5'd2, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    step("count_sat", 20);
    drive("hazard_off", 5'd9, 5'd2, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0);
    step("hold_sat", 2);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
